// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler
//   Buffers complete 16-byte TPIU frames from the trace decoder in a 2-slot
//   FIFO and streams them byte-wise to the UART transmitter. Every
//   SYNC_INTERVAL frames a full-sync marker (FF FF FF 7F) is sent ahead of
//   the frame. Also drives stretched activity/overflow indicators and
//   saturating sent/dropped frame counters.
// Ports
//   clk, rst_n          clock, async active-low reset
//   synced              decoder lock; frames are only taken while high
//   frame_data/_valid   128-bit frame + single-cycle strobe (byte 0 first)
//   tx_data/_valid/_ready  byte stream to the UART (valid/ready)
//   tx_ind, ovf_ind     stretched transmit / overflow indicators
//   frames_sent/_dropped  saturating 16-bit frame counters
module frame_tx_scheduler #(
  parameter int SYNC_INTERVAL = 8,
  parameter int LED_HOLD      = 1200000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         synced,
  input  logic [127:0] frame_data,
  input  logic         frame_valid,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_ind,
  output logic         ovf_ind,
  output logic [15:0]  frames_sent,
  output logic [15:0]  frames_dropped
);
  localparam int PW = (SYNC_INTERVAL > 1) ? $clog2(SYNC_INTERVAL) : 1;
  localparam int LW = $clog2(LED_HOLD + 1);

  typedef enum logic [1:0] {IDLE, MARK, DATA} state_t;

  state_t         r_state, w_state_n;
  logic [127:0]   r_slot [2];
  logic           r_head;
  logic [1:0]     r_cnt;
  logic [3:0]     r_idx;
  logic [PW-1:0]  r_phase;
  logic [15:0]    r_sent, r_drop;
  logic [LW-1:0]  r_tx_led, r_ovf_led;

  logic           w_xfer, w_free, w_cap, w_acc, w_drop, w_wptr;
  logic [1:0]     w_cnt_af;
  logic [127:0]   w_head_frame;

  assign w_xfer   = tx_valid & tx_ready;
  // Head slot frees on the edge that accepts its byte 15.
  assign w_free   = (r_state == DATA) & w_xfer & (r_idx == 4'd15);
  assign w_cap    = frame_valid & synced;
  // Occupancy after the free; a capture sees this (free-before-write).
  assign w_cnt_af = r_cnt - {1'b0, w_free};
  assign w_acc    = w_cap & (w_cnt_af != 2'd2);
  assign w_drop   = w_cap & ~w_acc;
  // Write slot = post-free head + post-free occupancy (mod 2).
  assign w_wptr   = r_head ^ w_free ^ w_cnt_af[0];
  assign w_head_frame = r_slot[r_head];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_state_n != r_state) r_idx <= '0;
      else if (w_xfer)          r_idx <= r_idx + 4'd1;
    end
  end

  // Next-state logic; IDLE only launches while synced so a slot discarded
  // by loss of lock is never started.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE: if (synced && r_cnt != 2'd0)
              w_state_n = (SYNC_INTERVAL != 0 && r_phase == '0) ? MARK : DATA;
      MARK: if (w_xfer && r_idx == 4'd3) w_state_n = DATA;
      DATA: if (w_free) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (r_state)
      MARK: begin
        tx_valid = 1'b1;
        tx_data  = (r_idx == 4'd3) ? 8'h7F : 8'hFF;
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_data  = w_head_frame[{r_idx, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  // Frame buffer. Losing lock keeps only the slot already being sent
  // (any non-IDLE state owns the head slot).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot[0] <= '0;
      r_slot[1] <= '0;
      r_head    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_head <= r_head ^ w_free;
      if (w_acc) r_slot[w_wptr] <= frame_data;
      if (!synced)
        r_cnt <= (r_state != IDLE && !w_free) ? 2'd1 : 2'd0;
      else
        r_cnt <= w_cnt_af + {1'b0, w_acc};
    end
  end

  // Marker phase and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_sent  <= '0;
      r_drop  <= '0;
    end else begin
      if (!synced || SYNC_INTERVAL <= 1)
        r_phase <= '0;
      else if (w_free)
        r_phase <= (r_phase == PW'(SYNC_INTERVAL - 1)) ? '0 : r_phase + 1'b1;
      if (w_free && r_sent != 16'hFFFF) r_sent <= r_sent + 16'd1;
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
  end

  // Indicator stretchers: reload on trigger, count down to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_led  <= '0;
      r_ovf_led <= '0;
    end else begin
      if (w_xfer)                r_tx_led <= LW'(LED_HOLD);
      else if (r_tx_led != '0)   r_tx_led <= r_tx_led - 1'b1;
      if (w_drop)                r_ovf_led <= LW'(LED_HOLD);
      else if (r_ovf_led != '0)  r_ovf_led <= r_ovf_led - 1'b1;
    end
  end

  assign tx_ind         = (r_tx_led != '0);
  assign ovf_ind        = (r_ovf_led != '0);
  assign frames_sent    = r_sent;
  assign frames_dropped = r_drop;
endmodule

// File: tb/tb_frame_tx_scheduler.sv
module tb_frame_tx_scheduler;
  localparam int SI = 8;
  localparam int LH = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         synced = 1'b0;
  logic [127:0] frame_data = '0;
  logic         frame_valid = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         tx_ind, ovf_ind;
  logic [15:0]  frames_sent, frames_dropped;

  frame_tx_scheduler #(.SYNC_INTERVAL(SI), .LED_HOLD(LH)) dut (
    .clk(clk), .rst_n(rst_n), .synced(synced),
    .frame_data(frame_data), .frame_valid(frame_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_ind(tx_ind), .ovf_ind(ovf_ind),
    .frames_sent(frames_sent), .frames_dropped(frames_dropped)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] mkf(input logic [7:0] b);
    logic [127:0] f;
    for (int k = 0; k < 16; k++) f[8*k +: 8] = 8'(b + k);
    return f;
  endfunction

  task automatic push_frame(input logic [127:0] f, input bit mk);
    if (mk) begin
      q.push_back(8'hFF); q.push_back(8'hFF); q.push_back(8'hFF); q.push_back(8'h7F);
    end
    for (int k = 0; k < 16; k++) q.push_back(f[8*k +: 8]);
  endtask

  // Monitor: bytes are sampled at negedge, ahead of the edge that takes them.
  logic [7:0] hold_d;
  bit stalled = 0;
  always @(negedge clk) begin
    if (!rst_n) stalled = 0;
    else begin
      if (stalled) chk("stall_hold", {tx_valid, tx_data}, {1'b1, hold_d});
      if (tx_valid && tx_ready) begin
        if (q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_byte actual=%0h required=none at %0t", tx_data, $time);
        end else chk("tx_byte", tx_data, q.pop_front());
        stalled = 0;
      end else if (tx_valid) begin
        stalled = 1; hold_d = tx_data;
      end else stalled = 0;
    end
  end

  task automatic strobe(input logic [127:0] f);
    @(posedge clk); #1 frame_data = f; frame_valid = 1'b1;
    @(posedge clk); #1 frame_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0; q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input bit toggle);
    int n;
    n = 0;
    while (n < 3000 && !(q.size() == 0 && !tx_valid)) begin
      @(posedge clk); #1;
      if (toggle) tx_ready = ~tx_ready;
      n++;
    end
    chk("drain_left", q.size(), 0);
    tx_ready = 1'b1;
  endtask

  initial begin
    int n;
    // Reset state
    #23;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_ind", {tx_ind, ovf_ind}, 0);
    chk("rst_sent", frames_sent, 0);
    chk("rst_dropped", frames_dropped, 0);
    synced = 1'b1; tx_ready = 1'b1;
    do_reset();

    // Test 1: single frame, marker first, E0+2 latency, no bubbles
    push_frame(mkf(8'h00), 1);
    @(posedge clk); #1 frame_data = mkf(8'h00); frame_valid = 1'b1;
    @(posedge clk); #1 frame_valid = 1'b0;
    chk("lat_e0p1", tx_valid, 0);
    @(posedge clk); #1;
    chk("lat_e0p2", tx_valid, 1);
    n = 0;
    while (tx_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("busy_cycles", n, 20);
    drain(0);
    chk("t1_sent", frames_sent, 1);
    chk("t1_tx_ind", tx_ind, 1);

    // Test 2: 9 frames, markers before 1st and 9th
    do_reset();
    for (int i = 0; i < 9; i++) begin
      push_frame(mkf(8'(i * 16)), (i == 0) || (i == 8));
      strobe(mkf(8'(i * 16)));
      repeat (38) @(posedge clk);
    end
    drain(0);
    chk("t2_sent", frames_sent, 9);
    chk("t2_dropped", frames_dropped, 0);

    // Test 3: overflow while UART stalled
    do_reset();
    #1 tx_ready = 1'b0;
    push_frame(mkf(8'h20), 1);
    push_frame(mkf(8'h40), 0);
    strobe(mkf(8'h20));
    strobe(mkf(8'h40));
    strobe(mkf(8'h60));
    chk("t3_dropped", frames_dropped, 1);
    chk("t3_ovf_ind", ovf_ind, 1);
    chk("t3_sent0", frames_sent, 0);
    tx_ready = 1'b1;
    drain(0);
    repeat (5) @(posedge clk);
    #1 chk("t3_sent", frames_sent, 2);
    repeat (LH + 2) @(posedge clk);
    #1 chk("t3_ovf_off", ovf_ind, 0);

    // Test 4: ready toggled every cycle
    do_reset();
    push_frame(mkf(8'h80), 1);
    strobe(mkf(8'h80));
    drain(1);
    chk("t4_sent", frames_sent, 1);

    // Test 5: lock lost mid-frame drops the queued frame silently
    do_reset();
    push_frame(mkf(8'hA0), 1);
    strobe(mkf(8'hA0));
    strobe(mkf(8'hB0));
    repeat (8) @(posedge clk);
    #1 synced = 1'b0;
    drain(0);
    repeat (5) @(posedge clk);
    #1 synced = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("t5_sent", frames_sent, 1);
    chk("t5_dropped", frames_dropped, 0);
    chk("t5_idle", tx_valid, 0);
    push_frame(mkf(8'hC0), 1);
    strobe(mkf(8'hC0));
    drain(0);
    chk("t5_sent2", frames_sent, 2);

    // Test 6: reset mid-DATA
    do_reset();
    push_frame(mkf(8'h10), 1);
    strobe(mkf(8'h10));
    drain(0);
    push_frame(mkf(8'h30), 0);
    strobe(mkf(8'h30));
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0; q.delete();
    #1;
    chk("t6_tx_valid", tx_valid, 0);
    chk("t6_sent", frames_sent, 0);
    chk("t6_dropped", frames_dropped, 0);
    chk("t6_tx_data", tx_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1 chk("t6_quiet", tx_valid, 0);
    chk("t6_sent_after", frames_sent, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/frame_tx_scheduler.md
# frame_tx_scheduler

Sequences complete 16-byte TPIU frames from the trace frame decoder into the byte-wide UART transmitter. Provides a 2-slot frame buffer, so the real-time, non-stallable trace side is decoupled from the slower UART. Periodically injects a TPIU full-sync marker (FF FF FF 7F) so the host can re-align. Also maintains the transmit/overflow LED indicators and the sent/dropped frame counters. Sits between the trace frame decoder and the UART transmitter in the top level.

## Interface

Parameters:
- SYNC_INTERVAL, 8: frames between injected sync markers; 0 disables injection.
- LED_HOLD, 1200000: clk cycles an indicator stays high after its last trigger; minimum 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- synced  in  1  decoder is locked to the TPIU stream.
- frame_data  in  128  frame contents; byte k = frame_data[8k+7:8k]; byte 0 is sent first.
- frame_valid  in  1  single-cycle strobe; frame_data is valid in that cycle.
- tx_data  out  8  byte to the UART.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART accepts a byte.
- tx_ind  out  1  stretched transmit-activity indicator.
- ovf_ind  out  1  stretched overflow indicator.
- frames_sent  out  16  saturating count of frames fully transmitted.
- frames_dropped  out  16  saturating count of frames lost to overflow.

## Operation

- Reset:
  - Every output is 0: tx_data 0x00, tx_valid 0, tx_ind 0, ovf_ind 0, both counters 0.
  - Both slots are empty, the FSM is in IDLE, and the sync phase counter is 0.
- Buffer:
  - Two 128-bit slots, handled in FIFO order (oldest frame first).
  - A frame is captured on any edge where frame_valid=1 and synced=1.
  - If both slots are occupied and neither frees on that edge, the new frame is discarded:
    - frames_dropped increments.
    - ovf_ind is (re)triggered.
  - A slot frees on the edge that accepts its last byte. A capture on that same edge succeeds (free-before-write).
- FSM states: IDLE, MARK, DATA.
  - IDLE → MARK if a slot is occupied, SYNC_INTERVAL≠0 and the phase counter is 0.
  - IDLE → DATA if a slot is occupied otherwise.
  - MARK: sends FF, FF, FF, 7F, then → DATA.
  - DATA: sends bytes 0..15 of the head slot. After byte 15 is accepted:
    - the head slot is freed;
    - frames_sent increments;
    - the phase counter = (phase+1) mod SYNC_INTERVAL;
    - the FSM → IDLE.
  - A 4-bit byte index is used in both MARK and DATA; it resets to 0 on every state entry.
- Handshake:
  - A byte transfers on an edge where tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data is held stable.
  - tx_valid never drops until its byte transfers.
- synced=0 (level):
  - frame_valid is ignored; this is not counted as a drop.
  - A byte stream in MARK or DATA completes normally.
  - Any queued slot that is not yet in flight is discarded without being counted.
  - The phase counter is forced to 0, so the first frame after re-lock is preceded by a marker when SYNC_INTERVAL≠0.
- Counters saturate at 0xFFFF; they never wrap.
- Indicators:
  - tx_ind goes high on each byte transfer and stays high LED_HOLD cycles after the last one; each transfer retriggers it.
  - ovf_ind behaves the same way on each drop.

## Timing

- Latency: for a frame strobed at edge E0 with the FSM in IDLE and both slots empty, tx_valid is high after edge E0+2 (one cycle for capture, one for the FSM decision).
- Within MARK followed by DATA, and within DATA, tx_valid stays high: with tx_ready held at 1, one byte transfers per cycle with no bubbles.
- Between consecutive frames there is exactly one IDLE cycle with tx_valid=0.
- Back-to-back frame with tx_ready=1 and no marker: 16 transfer cycles plus 1 IDLE cycle, i.e. 17 cycles per frame.
- Asserting rst_n low at any point, including mid-frame, immediately returns all state to the reset values. No partial frame resumes after reset.

## Test plan

- Reset, synced=1, SYNC_INTERVAL=8, tx_ready=1; strobe frame 0x0F0E…0100 (byte k = k) → tx stream FF FF FF 7F 00 01 … 0F; tx_valid first high at E0+2; frames_sent=1; tx_ind high.
- Strobe 9 frames spaced 40 cycles apart → a marker precedes frame 1 and frame 9 only; frames_sent=9; frames_dropped=0.
- tx_ready=0; strobe 3 frames → frames 1 and 2 are retained, frames_dropped=1, ovf_ind=1. Then set tx_ready=1 → exactly 2 frames are emitted, in order.
- Stall mid-frame: toggle tx_ready 1/0 every cycle → tx_data is held during stalls, no byte is skipped or duplicated, and the 16 bytes arrive in order.
- Two frames queued; drop synced to 0 in the middle of the first frame → the first frame completes, the second is never sent, frames_dropped is unchanged. Re-assert synced and strobe a new frame → a marker precedes it.
- Assert rst_n low mid-DATA → tx_valid=0 and both counters=0 immediately; after release, no bytes are sent until a new frame_valid.
